// File: rtl/slot_alloc_pkg.sv
// Shared definitions for the slot allocator.
//   mode_e   : search mode (fixed priority or round-robin)
//   popcount : number of set bits in a vector of up to 256 bits
package slot_alloc_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  function automatic int popcount(input logic [255:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 256; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/slot_alloc_find.sv
// first_zero_find: combinational search for the first zero bit of vec_i.
// The search starts at start_i and walks ascending (LSB_FIRST=1) or
// descending (LSB_FIRST=0), wrapping modulo N.
//   vec_i    : N-bit vector to search
//   start_i  : first position examined (must be < N)
//   found_o  : a zero bit exists
//   idx_o    : binary index of that zero (0 when none)
//   onehot_o : one-hot of that zero (all zero when none)
module first_zero_find #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1,
  localparam int IW       = $clog2(N)
) (
  input  logic [N-1:0]  vec_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o,
  output logic [N-1:0]  onehot_o
);

  always_comb begin
    int p;
    logic [IW-1:0] pos;
    found_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    p        = 0;
    pos      = '0;
    for (int k = 0; k < N; k++) begin
      // Wrapped position of the k-th candidate in the search direction.
      if (LSB_FIRST) begin
        p = int'(start_i) + k;
        if (p >= N) p = p - N;
      end else begin
        p = int'(start_i) - k;
        if (p < 0) p = p + N;
      end
      pos = p[IW-1:0];
      if (!found_o && !vec_i[pos]) begin
        found_o       = 1'b1;
        idx_o         = pos;
        onehot_o[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/slot_alloc.sv
// slot_alloc: sequential free-slot allocator for a pool of N entries.
// Offers the first free slot over a valid/ready port; slots come back
// through the free port. Every output is a function of registers only.
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   alloc_valid_o/ready_i   : allocate handshake
//   alloc_idx_o/onehot_o    : offered slot (zero when nothing offered)
//   free_valid_i/free_idx_i : return a slot
//   occ_o                   : occupancy bitmap (1 = allocated)
//   free_cnt_o, full_o      : free slot count, pool exhausted
//   err_o                   : one-cycle pulse per illegal free
module slot_alloc
  import slot_alloc_pkg::*;
#(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int MODE      = 0,
  localparam int IW       = $clog2(N),
  localparam int CW       = $clog2(N + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic          alloc_valid_o,
  input  logic          alloc_ready_i,
  output logic [IW-1:0] alloc_idx_o,
  output logic [N-1:0]  alloc_onehot_o,
  input  logic          free_valid_i,
  input  logic [IW-1:0] free_idx_i,
  output logic [N-1:0]  occ_o,
  output logic [CW-1:0] free_cnt_o,
  output logic          full_o,
  output logic          err_o
);

  localparam bit            RR      = (MODE == int'(MODE_RR));
  localparam logic [IW-1:0] LAST    = IW'(N - 1);
  localparam logic [IW-1:0] RST_PTR = LSB_FIRST ? '0 : LAST;
  localparam logic [IW:0]   N_EXT   = (IW + 1)'(N);

  logic [N-1:0]  occ_q, occ_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          fz_found;
  logic [IW-1:0] fz_idx;
  logic [N-1:0]  fz_onehot;
  logic [IW-1:0] search_start;
  logic          alloc_fire;
  logic          free_legal;

  // Fixed priority always searches from the end the direction starts at.
  assign search_start = RR ? ptr_q : RST_PTR;

  first_zero_find #(
    .N         (N),
    .LSB_FIRST (LSB_FIRST)
  ) u_find (
    .vec_i    (occ_q),
    .start_i  (search_start),
    .found_o  (fz_found),
    .idx_o    (fz_idx),
    .onehot_o (fz_onehot)
  );

  assign alloc_valid_o  = ~&occ_q;
  assign alloc_idx_o    = (alloc_valid_o && fz_found) ? fz_idx : '0;
  assign alloc_onehot_o = alloc_valid_o ? fz_onehot : '0;
  assign occ_o          = occ_q;
  assign free_cnt_o     = cnt_q;
  assign full_o         = (cnt_q == '0);
  assign err_o          = err_q;

  assign alloc_fire = alloc_valid_o && alloc_ready_i;
  // Out-of-range index is rejected before the bitmap is looked at.
  assign free_legal = free_valid_i && ({1'b0, free_idx_i} < N_EXT) && occ_q[free_idx_i];

  always_comb begin
    occ_d = occ_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = free_valid_i && !free_legal;
    // The offered slot is free in occ_q, so it never collides with a legal free.
    if (alloc_fire) occ_d = occ_d | alloc_onehot_o;
    if (free_legal) occ_d[free_idx_i] = 1'b0;
    if (alloc_fire && !free_legal) cnt_d = cnt_q - CW'(1);
    if (!alloc_fire && free_legal) cnt_d = cnt_q + CW'(1);
    if (RR && alloc_fire) begin
      if (LSB_FIRST) ptr_d = (alloc_idx_o == LAST) ? '0 : alloc_idx_o + IW'(1);
      else           ptr_d = (alloc_idx_o == '0) ? LAST : alloc_idx_o - IW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q <= '0;
      ptr_q <= RST_PTR;
      cnt_q <= CW'(N);
      err_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  a_cnt_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    int'(cnt_q) <= N);
  a_cnt_pop : assert property (@(posedge clk_i) disable iff (!rst_ni)
    int'(cnt_q) == N - popcount(256'(occ_q)));

endmodule

// File: tb/tb_slot_alloc.sv
module tb_slot_alloc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // A: N=8 LSB-first fixed, B: N=8 MSB-first fixed, C: N=6 fixed, D: N=8 round-robin
  logic       a_rdy, a_fv, a_vld, a_full, a_err;
  logic [2:0] a_fi, a_idx;
  logic [7:0] a_oh, a_occ;
  logic [3:0] a_cnt;

  logic       b_rdy, b_fv, b_vld, b_full, b_err;
  logic [2:0] b_fi, b_idx;
  logic [7:0] b_oh, b_occ;
  logic [3:0] b_cnt;

  logic       c_rdy, c_fv, c_vld, c_full, c_err;
  logic [2:0] c_fi, c_idx;
  logic [5:0] c_oh, c_occ;
  logic [2:0] c_cnt;

  logic       d_rdy, d_fv, d_vld, d_full, d_err;
  logic [2:0] d_fi, d_idx;
  logic [7:0] d_oh, d_occ;
  logic [3:0] d_cnt;

  slot_alloc #(.N(8), .LSB_FIRST(1'b1), .MODE(0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .alloc_valid_o(a_vld), .alloc_ready_i(a_rdy),
    .alloc_idx_o(a_idx), .alloc_onehot_o(a_oh), .free_valid_i(a_fv), .free_idx_i(a_fi),
    .occ_o(a_occ), .free_cnt_o(a_cnt), .full_o(a_full), .err_o(a_err));

  slot_alloc #(.N(8), .LSB_FIRST(1'b0), .MODE(0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .alloc_valid_o(b_vld), .alloc_ready_i(b_rdy),
    .alloc_idx_o(b_idx), .alloc_onehot_o(b_oh), .free_valid_i(b_fv), .free_idx_i(b_fi),
    .occ_o(b_occ), .free_cnt_o(b_cnt), .full_o(b_full), .err_o(b_err));

  slot_alloc #(.N(6), .LSB_FIRST(1'b1), .MODE(0)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .alloc_valid_o(c_vld), .alloc_ready_i(c_rdy),
    .alloc_idx_o(c_idx), .alloc_onehot_o(c_oh), .free_valid_i(c_fv), .free_idx_i(c_fi),
    .occ_o(c_occ), .free_cnt_o(c_cnt), .full_o(c_full), .err_o(c_err));

  slot_alloc #(.N(8), .LSB_FIRST(1'b1), .MODE(1)) u_d (
    .clk_i(clk), .rst_ni(rst_n), .alloc_valid_o(d_vld), .alloc_ready_i(d_rdy),
    .alloc_idx_o(d_idx), .alloc_onehot_o(d_oh), .free_valid_i(d_fv), .free_idx_i(d_fi),
    .occ_o(d_occ), .free_cnt_o(d_cnt), .full_o(d_full), .err_o(d_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int fl[5] = '{2, 4, 5, 6, 7};

  initial begin
    {a_rdy, a_fv, b_rdy, b_fv, c_rdy, c_fv, d_rdy, d_fv} = '0;
    a_fi = '0; b_fi = '0; c_fi = '0; d_fi = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk("a_rst_valid",  32'(a_vld), 1);
    chk("a_rst_idx",    32'(a_idx), 0);
    chk("a_rst_onehot", 32'(a_oh),  'h01);
    chk("a_rst_cnt",    32'(a_cnt), 8);
    chk("a_rst_occ",    32'(a_occ), 0);
    chk("a_rst_err",    32'(a_err), 0);
    chk("a_rst_full",   32'(a_full), 0);
    chk("b_rst_idx",    32'(b_idx), 7);
    chk("b_rst_onehot", 32'(b_oh),  'h80);
    chk("d_rst_idx",    32'(d_idx), 0);

    // A: hold ready 9 cycles, grants 0..7 then nothing
    a_rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) chk("a_fill_idx", 32'(a_idx), 32'(i));
      tick();
    end
    a_rdy = 1'b0;
    chk("a_full_full",   32'(a_full), 1);
    chk("a_full_valid",  32'(a_vld),  0);
    chk("a_full_cnt",    32'(a_cnt),  0);
    chk("a_full_occ",    32'(a_occ),  'hFF);
    chk("a_full_idx",    32'(a_idx),  0);
    chk("a_full_onehot", 32'(a_oh),   0);

    // A: free 3 from full pool
    a_fv = 1'b1; a_fi = 3'd3;
    tick();
    a_fv = 1'b0;
    chk("a_free3_valid", 32'(a_vld), 1);
    chk("a_free3_idx",   32'(a_idx), 3);
    chk("a_free3_cnt",   32'(a_cnt), 1);
    chk("a_free3_occ",   32'(a_occ), 'hF7);

    // A: return 2,4,5,6,7 -> occ = 00000011
    a_fv = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a_fi = 3'(fl[k]);
      tick();
    end
    a_fv = 1'b0;
    chk("a_pre_occ", 32'(a_occ), 'h03);
    chk("a_pre_cnt", 32'(a_cnt), 6);
    chk("a_pre_idx", 32'(a_idx), 2);

    // A: allocate 2 and free 0 together
    a_rdy = 1'b1; a_fv = 1'b1; a_fi = 3'd0;
    tick();
    a_rdy = 1'b0; a_fv = 1'b0;
    chk("a_sim_occ", 32'(a_occ), 'h06);
    chk("a_sim_cnt", 32'(a_cnt), 6);
    chk("a_sim_idx", 32'(a_idx), 0);

    // A: free an already-free slot
    a_fv = 1'b1; a_fi = 3'd4;
    tick();
    a_fv = 1'b0;
    chk("a_ill_err", 32'(a_err), 1);
    chk("a_ill_occ", 32'(a_occ), 'h06);
    chk("a_ill_cnt", 32'(a_cnt), 6);
    tick();
    chk("a_ill_err_drop", 32'(a_err), 0);

    // A: two illegal frees back to back
    a_fv = 1'b1; a_fi = 3'd3;
    tick();
    chk("a_ill2_err1", 32'(a_err), 1);
    tick();
    a_fv = 1'b0;
    chk("a_ill2_err2", 32'(a_err), 1);
    tick();
    chk("a_ill2_err3", 32'(a_err), 0);
    chk("a_ill2_occ",  32'(a_occ), 'h06);

    // B: MSB-first single allocate
    b_rdy = 1'b1;
    tick();
    b_rdy = 1'b0;
    chk("b_idx_after", 32'(b_idx), 6);
    chk("b_occ_after", 32'(b_occ), 'h80);
    chk("b_cnt_after", 32'(b_cnt), 7);

    // C: N=6, out-of-range free, then fill
    c_fv = 1'b1; c_fi = 3'd7;
    tick();
    c_fv = 1'b0;
    chk("c_oor_err", 32'(c_err), 1);
    chk("c_oor_occ", 32'(c_occ), 0);
    chk("c_oor_cnt", 32'(c_cnt), 6);
    c_rdy = 1'b1;
    repeat (6) tick();
    c_rdy = 1'b0;
    chk("c_full_full",  32'(c_full), 1);
    chk("c_full_occ",   32'(c_occ),  'h3F);
    chk("c_full_valid", 32'(c_vld),  0);

    // D: round-robin
    d_rdy = 1'b1;
    tick();
    d_rdy = 1'b0;
    chk("d_a0_occ", 32'(d_occ), 'h01);
    chk("d_a0_idx", 32'(d_idx), 1);
    d_fv = 1'b1; d_fi = 3'd0;
    tick();
    d_fv = 1'b0;
    chk("d_f0_occ", 32'(d_occ), 0);
    chk("d_f0_idx", 32'(d_idx), 1);
    d_rdy = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk("d_rr_idx", 32'(d_idx), 32'(i));
      tick();
    end
    chk("d_wrap_idx", 32'(d_idx), 0);
    chk("d_wrap_occ", 32'(d_occ), 'hFE);
    chk("d_wrap_cnt", 32'(d_cnt), 1);

    // D: asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("d_rst_occ", 32'(d_occ), 0);
    chk("d_rst_idx", 32'(d_idx), 0);
    chk("d_rst_cnt", 32'(d_cnt), 8);
    d_rdy = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
